// File: rtl/usb_tx_ctrl_pkg.sv
// Package usb_tx_pkg: shared types and constants for the USB transmit sequencer.
//   tx_state_t  - packet sequencer states
//   pkt_type_t  - requested packet kind (ACK, NAK, DATA0, DATA1)
//   PID_*       - 4-bit PID codes; the wire byte is {~pid, pid}
//   CRC16_*     - USB CRC16 polynomial (normal form) and seed
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC      = 3'd1,
    ST_PID       = 3'd2,
    ST_DATA      = 3'd3,
    ST_CRC_LO    = 3'd4,
    ST_CRC_HI    = 3'd5,
    ST_PAD       = 3'd6,
    ST_WAIT_DONE = 3'd7
  } tx_state_t;

  typedef enum logic [1:0] {
    PKT_ACK   = 2'b00,
    PKT_NAK   = 2'b01,
    PKT_DATA0 = 2'b10,
    PKT_DATA1 = 2'b11
  } pkt_type_t;

  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // The CRC register shifts right because USB sends bits LSB-first,
  // so the polynomial is applied in bit-reversed form.
  localparam logic [15:0] CRC16_POLY_REFL = reflect16(CRC16_POLY);

  function automatic logic [7:0] pid_byte(input pkt_type_t t);
    logic [3:0] p;
    case (t)
      PKT_ACK:   p = PID_ACK;
      PKT_NAK:   p = PID_NAK;
      PKT_DATA0: p = PID_DATA0;
      default:   p = PID_DATA1;
    endcase
    return {~p, p};
  endfunction

endpackage

// File: rtl/usb_tx_ctrl_if.sv
// Interface bundling the request, TX FIFO, timer and shifter signals of the
// USB transmit sequencer.
//   master : environment side (requester, FIFO, timer, shifter)
//   slave  : usb_tx_ctrl side
interface usb_tx_ctrl_if;
  logic       send_req;
  logic [1:0] pkt_type;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       byte_sent;
  logic       data_sent;
  logic       transmitting;
  logic       transmit_empty;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic       busy;
  logic       done;
  logic       underrun;

  modport master (
    output send_req, pkt_type, fifo_rdata, fifo_empty, byte_sent, data_sent,
    input  fifo_rd, transmitting, transmit_empty, tx_byte, tx_load, busy, done,
           underrun
  );

  modport slave (
    input  send_req, pkt_type, fifo_rdata, fifo_empty, byte_sent, data_sent,
    output fifo_rd, transmitting, transmit_empty, tx_byte, tx_load, busy, done,
           underrun
  );
endinterface

// File: rtl/usb_tx_ctrl_crc16.sv
// usb_crc16: byte-wide USB CRC16 accumulator, one byte per cycle.
//   clk, n_rst : clock, asynchronous active-low reset (crc -> 16'hFFFF)
//   clear      : reload the seed
//   enable     : fold data_in into the CRC (LSB of data_in first)
//   crc_out    : running CRC register (not complemented)
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  function automatic logic [15:0] crc_step(input logic [15:0] c_in,
                                           input logic [7:0]  d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC16_POLY_REFL;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      crc_out <= CRC16_INIT;
    else if (clear)  crc_out <= CRC16_INIT;
    else if (enable) crc_out <= crc_step(crc_out, data_in);
  end

endmodule

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: USB transmit packet sequencer.
// Emits SYNC, PID, then either 30 FIFO payload bytes plus CRC16 (DATA0/1)
// or three pad bytes (ACK/NAK), one byte per timer byte_sent pulse, and
// finishes when the external timer reports data_sent.
//   clk, n_rst      : clock, asynchronous active-low reset
//   bus (slave)     : send_req/pkt_type request, FIFO read side, timer
//                     pulses, shifter load, busy/done/underrun status
module usb_tx_ctrl
  import usb_tx_pkg::*;
#(
  parameter int         DATA_BYTES = 30,
  parameter logic [7:0] SYNC_BYTE  = 8'h80
) (
  input  logic         clk,
  input  logic         n_rst,
  usb_tx_ctrl_if.slave bus
);

  localparam int CNT_W = ($clog2(DATA_BYTES) < 2) ? 2 : $clog2(DATA_BYTES);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(2);

  tx_state_t        state;
  pkt_type_t        pkt_q;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      crc;
  logic             is_data;
  logic             advance;
  logic             pay_step;
  logic             crc_clear;
  logic [7:0]       pay_byte;

  assign is_data = pkt_q[1];

  // data_sent overrides a coincident byte_sent
  assign advance = bus.byte_sent & ~bus.data_sent;

  // Byte boundary that loads a payload byte: entering DATA or moving on
  // to the next payload byte.
  assign pay_step = advance &
                    (((state == ST_PID) & is_data) |
                     ((state == ST_DATA) & (cnt != DATA_LAST)));

  // An empty FIFO is never popped; a zero byte keeps the packet length.
  assign bus.fifo_rd = pay_step & ~bus.fifo_empty;
  assign pay_byte    = bus.fifo_empty ? 8'h00 : bus.fifo_rdata;

  assign crc_clear = ((state == ST_IDLE) & bus.send_req) |
                     ((state != ST_IDLE) & bus.data_sent);

  assign bus.busy           = (state != ST_IDLE);
  assign bus.transmitting   = (state != ST_IDLE);
  assign bus.transmit_empty = (state != ST_IDLE) & ~pkt_q[1];

  usb_crc16 u_crc (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (crc_clear),
    .enable  (pay_step),
    .data_in (pay_byte),
    .crc_out (crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      pkt_q        <= PKT_ACK;
      cnt          <= '0;
      bus.tx_byte  <= 8'h00;
      bus.tx_load  <= 1'b0;
      bus.done     <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      bus.tx_load <= 1'b0;
      bus.done    <= 1'b0;
      if (state == ST_IDLE) begin
        if (bus.send_req) begin
          pkt_q        <= pkt_type_t'(bus.pkt_type);
          bus.underrun <= 1'b0;
          state        <= ST_SYNC;
          bus.tx_byte  <= SYNC_BYTE;
          bus.tx_load  <= 1'b1;
        end
      end else if (bus.data_sent) begin
        // Completion; anywhere but WAIT_DONE it means the timer and the
        // sequencer disagree on the packet length, so flag it.
        state    <= ST_IDLE;
        bus.done <= 1'b1;
        if (state != ST_WAIT_DONE) bus.underrun <= 1'b1;
      end else if (bus.byte_sent) begin
        case (state)
          ST_SYNC: begin
            state       <= ST_PID;
            bus.tx_byte <= pid_byte(pkt_q);
            bus.tx_load <= 1'b1;
          end
          ST_PID: begin
            cnt         <= '0;
            bus.tx_load <= 1'b1;
            if (is_data) begin
              state       <= ST_DATA;
              bus.tx_byte <= pay_byte;
              if (bus.fifo_empty) bus.underrun <= 1'b1;
            end else begin
              state       <= ST_PAD;
              bus.tx_byte <= 8'h00;
            end
          end
          ST_DATA: begin
            bus.tx_load <= 1'b1;
            if (cnt == DATA_LAST) begin
              state       <= ST_CRC_LO;
              bus.tx_byte <= ~crc[7:0];
            end else begin
              cnt         <= cnt + 1'b1;
              bus.tx_byte <= pay_byte;
              if (bus.fifo_empty) bus.underrun <= 1'b1;
            end
          end
          ST_CRC_LO: begin
            state       <= ST_CRC_HI;
            bus.tx_byte <= ~crc[15:8];
            bus.tx_load <= 1'b1;
          end
          ST_CRC_HI: state <= ST_WAIT_DONE;
          ST_PAD: begin
            if (cnt == PAD_LAST) begin
              state <= ST_WAIT_DONE;
            end else begin
              cnt         <= cnt + 1'b1;
              bus.tx_byte <= 8'h00;
              bus.tx_load <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Testbench for usb_tx_ctrl: scoreboard of expected shifter bytes, FIFO and
// timer models, directed scenarios plus randomized packets.
module tb_usb_tx_ctrl;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_tx_ctrl_if bus ();

  usb_tx_ctrl #(.DATA_BYTES(30), .SYNC_BYTE(8'h80)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  bq_t  fifo_q;
  bq_t  exp_q;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   rd_cnt = 0;
  logic exp_te = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference CRC: USB CRC16 computed as a straight polynomial division of
  // the serial bit stream (normal MSB-first register), then bit-reversed to
  // the order in which it goes on the wire.
  function automatic logic [15:0] crc_model(input bq_t d);
    logic [15:0] r;
    logic [15:0] c;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < d.size(); i++)
      for (int b = 0; b < 8; b++) begin
        fb = r[15] ^ d[i][b];
        r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    for (int k = 0; k < 16; k++) c[k] = r[15-k];
    return c;
  endfunction

  function automatic logic [7:0] pid_model(input logic [1:0] t);
    case (t)
      2'b00:   return 8'hD2;
      2'b01:   return 8'h5A;
      2'b10:   return 8'hC3;
      default: return 8'h4B;
    endcase
  endfunction

  function automatic bq_t build(input logic [1:0] t, input bq_t f);
    bq_t         q;
    bq_t         pay;
    logic [15:0] c;
    q.push_back(8'h80);
    q.push_back(pid_model(t));
    if (t[1]) begin
      for (int i = 0; i < 30; i++) pay.push_back(i < f.size() ? f[i] : 8'h00);
      c = crc_model(pay);
      for (int i = 0; i < 30; i++) q.push_back(pay[i]);
      q.push_back(~c[7:0]);
      q.push_back(~c[15:8]);
    end else begin
      repeat (3) q.push_back(8'h00);
    end
    return q;
  endfunction

  // FIFO model: first-word-fall-through; a pop seen in one cycle takes
  // effect at the following rising edge.
  initial begin : fifo_model
    logic rd;
    bus.fifo_rdata = 8'h00;
    bus.fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd = bus.fifo_rd;
      @(posedge clk);
      if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      #1;
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Monitor: every shifter load is matched against the scoreboard.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.tx_load) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: tx_byte %0h with nothing expected at %0t",
                   bus.tx_byte, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", bus.tx_byte, e);
          check("transmit_empty", bus.transmit_empty, exp_te);
        end
      end
      if (bus.done) done_cnt++;
      if (bus.fifo_rd) begin
        rd_cnt++;
        check("fifo_rd_while_empty", bus.fifo_empty, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_transmitting"}, bus.transmitting, 1'b0);
    check({tag, "_tx_load"}, bus.tx_load, 1'b0);
    check({tag, "_tx_byte"}, bus.tx_byte, 8'h00);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_underrun"}, bus.underrun, 1'b0);
    check({tag, "_transmit_empty"}, bus.transmit_empty, 1'b0);
    check({tag, "_fifo_rd"}, bus.fifo_rd, 1'b0);
  endtask

  // mode 0: full packet; 1: extra send_req while in PID;
  // 2: reset after 'cut' byte_sent pulses; 3: early data_sent after 'cut'.
  task automatic run_pkt(input logic [1:0] t, input int mode, input int cut);
    bq_t  full;
    int   total, nbs, nloads, d0, r0, f0, steps, exp_rd;
    logic exp_ur;
    full   = build(t, fifo_q);
    total  = t[1] ? 34 : 5;
    nbs    = (mode >= 2) ? cut : total;
    nloads = (mode >= 2) ? cut + 1 : total;
    for (int i = 0; i < nloads; i++) exp_q.push_back(full[i]);
    exp_te = ~t[1];
    d0 = done_cnt;
    r0 = rd_cnt;
    f0 = fifo_q.size();
    steps  = t[1] ? ((mode >= 2) ? ((cut >= 2) ? cut - 1 : 0) : 30) : 0;
    exp_rd = (steps < f0) ? steps : f0;
    exp_ur = (mode == 3) ? 1'b1 : (t[1] && f0 < 30);

    bus.pkt_type = t;
    bus.send_req = 1'b1;
    cyc(1);
    bus.send_req = 1'b0;
    bus.pkt_type = 2'($urandom);
    check("start_load_latency", bus.tx_load, 1'b1);
    check("start_busy", bus.busy, 1'b1);

    for (int i = 0; i < nbs; i++) begin
      cyc($urandom_range(3, 9));
      bus.byte_sent = 1'b1;
      cyc(1);
      bus.byte_sent = 1'b0;
      if (mode == 1 && i == 0) begin
        cyc(1);
        bus.send_req = 1'b1;
        bus.pkt_type = 2'($urandom);
        cyc(1);
        bus.send_req = 1'b0;
      end
    end

    if (mode == 2) begin
      cyc(3);
      check("pre_reset_loads_drained", exp_q.size(), 0);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      check("fifo_untouched_by_reset", fifo_q.size(), f0 - exp_rd);
      cyc(2);
      n_rst = 1'b1;
      cyc(2);
      check("no_done_on_reset", done_cnt - d0, 0);
    end else begin
      cyc(2);
      bus.data_sent = 1'b1;
      cyc(1);
      bus.data_sent = 1'b0;
      @(negedge clk);
      check("done_pulse", bus.done, 1'b1);
      check("end_busy", bus.busy, 1'b0);
      check("end_transmitting", bus.transmitting, 1'b0);
      check("end_transmit_empty", bus.transmit_empty, 1'b0);
      check("end_underrun", bus.underrun, exp_ur);
      cyc(2);
      check("all_loads_seen", exp_q.size(), 0);
      check("done_count", done_cnt - d0, 1);
      check("fifo_rd_count", rd_cnt - r0, exp_rd);
      check("done_one_cycle", bus.done, 1'b0);
    end
    exp_q.delete();
  endtask

  task automatic fill_random(input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
  endtask

  initial begin : stimulus
    logic [1:0] t;
    bus.send_req  = 1'b0;
    bus.pkt_type  = 2'b00;
    bus.byte_sent = 1'b0;
    bus.data_sent = 1'b0;
    n_rst = 1'b0;
    cyc(3);
    check_idle_outputs("reset");
    n_rst = 1'b1;
    cyc(2);

    // ACK handshake
    run_pkt(2'b00, 0, 0);

    // DATA0 with an ascending payload
    fifo_q.delete();
    for (int i = 0; i < 30; i++) fifo_q.push_back(8'(i));
    cyc(2);
    run_pkt(2'b10, 0, 0);
    check("fifo_drained", fifo_q.size(), 0);

    // DATA1 with only 10 payload bytes available
    fill_random(10);
    cyc(2);
    run_pkt(2'b11, 0, 0);

    // send_req during PID of a NAK is ignored
    run_pkt(2'b01, 1, 0);

    // reset while DATA byte 5 is loaded, then a fresh DATA0
    fill_random(30);
    cyc(2);
    run_pkt(2'b10, 2, 7);
    while (fifo_q.size() < 30) fifo_q.push_back(8'($urandom));
    cyc(2);
    run_pkt(2'b10, 0, 0);

    // data_sent during DATA byte 3
    fill_random(30);
    cyc(2);
    run_pkt(2'b11, 3, 5);
    fifo_q.delete();
    cyc(2);

    // randomized packets and FIFO fill levels
    for (int k = 0; k < 6; k++) begin
      t = 2'($urandom);
      fill_random($urandom_range(0, 34));
      cyc(2);
      run_pkt(t, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
